// File: rtl/apu_shared_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apu_shared_arbiter_pkg
//   Shared constants, types and helpers for the shared-APU arbiter slice.
//   APU_ARB_MAX_MASTERS : largest supported number of requesting cores
//   APU_ARB_IDX_W       : master-index width for the default configuration
//   arb_state_e         : selection lock state (open / locked on a master)
//   arb_idx_w()         : master-index width for any NUM_MASTERS (min 1 bit)
// ---------------------------------------------------------------------------
package apu_shared_arbiter_pkg;

  localparam int unsigned APU_ARB_MAX_MASTERS = 8;
  localparam int unsigned APU_ARB_DEF_MASTERS = 2;
  localparam int unsigned APU_ARB_IDX_W       = $clog2(APU_ARB_DEF_MASTERS);

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apu_shared_arbiter_if.sv
// ---------------------------------------------------------------------------
// apu_shared_arbiter_if
//   Bundles the core-side dispatcher signals and the shared-APU port.
//   Core side : m_req_i, m_payload_i, m_gnt_o, m_ready_i, m_valid_o, m_result_o
//   APU side  : apu_req_o, apu_payload_o, apu_gnt_i, apu_valid_i,
//               apu_result_i, apu_ready_o
//   Modports:
//     slave  - the arbiter view (drives the *_o signals)
//     master - the environment view (cores + APU, drives the *_i signals)
// ---------------------------------------------------------------------------
interface apu_shared_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned REQ_W       = 108,
  parameter int unsigned RESP_W      = 37
);

  logic [NUM_MASTERS-1:0]       m_req_i;
  logic [NUM_MASTERS*REQ_W-1:0] m_payload_i;
  logic [NUM_MASTERS-1:0]       m_gnt_o;
  logic [NUM_MASTERS-1:0]       m_ready_i;
  logic [NUM_MASTERS-1:0]       m_valid_o;
  logic [RESP_W-1:0]            m_result_o;
  logic                         apu_req_o;
  logic [REQ_W-1:0]             apu_payload_o;
  logic                         apu_gnt_i;
  logic                         apu_valid_i;
  logic [RESP_W-1:0]            apu_result_i;
  logic                         apu_ready_o;

  modport slave (
    input  m_req_i, m_payload_i, m_ready_i, apu_gnt_i, apu_valid_i, apu_result_i,
    output m_gnt_o, m_valid_o, m_result_o, apu_req_o, apu_payload_o, apu_ready_o
  );

  modport master (
    output m_req_i, m_payload_i, m_ready_i, apu_gnt_i, apu_valid_i, apu_result_i,
    input  m_gnt_o, m_valid_o, m_result_o, apu_req_o, apu_payload_o, apu_ready_o
  );

endinterface

// File: rtl/apu_arb_tag_fifo.sv
// ---------------------------------------------------------------------------
// apu_arb_tag_fifo
//   In-order owner-tag FIFO: one entry per accepted, not-yet-returned APU op.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i/data_i : enqueue an owner index (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   head_o        : owner of the oldest outstanding op
//   full_o/empty_o/count_o : occupancy
//   DEPTH must be a power of two so pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module apu_arb_tag_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/apu_shared_arbiter.sv
// ---------------------------------------------------------------------------
// apu_shared_arbiter
//   Shares one APU between NUM_MASTERS core dispatchers: round-robin request
//   arbitration, in-order owner tracking of outstanding ops, and routing of
//   each APU response back to the issuing master.
//   clk_i  : clock
//   rst_ni : async active-low reset (drops all outstanding tags)
//   bus    : core-side and APU-side handshake signals (slave modport)
//   busy_o : at least one op outstanding
//   err_o  : sticky, a response arrived with nothing outstanding
//
//   Lock state | meaning
//   -----------+----------------------------------------------------------
//   ARB_OPEN   | winner chosen round-robin from rr_ptr each cycle
//   ARB_LOCKED | request offered but not yet granted; winner pinned to
//              | lock_idx so the APU payload cannot change mid-handshake
// ---------------------------------------------------------------------------
module apu_shared_arbiter
  import apu_shared_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned MAX_OUTST   = 4,
  parameter int unsigned REQ_W       = 108,
  parameter int unsigned RESP_W      = 37
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  apu_shared_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned IDX_W = arb_idx_w(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic             found;
  logic             apu_req;
  logic             accept;
  logic             bypass;
  logic             push;
  logic             pop;
  logic [IDX_W-1:0] owner;
  logic             owner_vld;
  logic             apu_ready;

  logic [IDX_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic [REQ_W-1:0] payload [NUM_MASTERS];

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      payload[i] = bus.m_payload_i[i*REQ_W +: REQ_W];
    end
  end

  // Winner selection: pinned while locked, otherwise first requester at or
  // after rr_ptr (wrapping). With no requester the winner is irrelevant.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    if (state_q == ARB_LOCKED) begin
      winner = lock_idx_q;
    end else begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
        if (!found && bus.m_req_i[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    // A full FIFO blocks requests even if a pop happens this cycle, keeping
    // apu_valid_i off the combinational path to apu_req_o.
    apu_req = bus.m_req_i[winner] & ~fifo_full;
    accept  = apu_req & bus.apu_gnt_i;
    // Single-cycle op: response arrives with the accept while nothing is
    // outstanding, so it is routed directly and never enters the FIFO.
    bypass    = accept & fifo_empty & bus.apu_valid_i;
    push      = accept & ~bypass;
    owner_vld = ~fifo_empty | bypass;
    owner     = fifo_empty ? winner : fifo_head;
    apu_ready = owner_vld ? bus.m_ready_i[owner] : 1'b1;
    pop       = bus.apu_valid_i & apu_ready & ~fifo_empty;

    bus.apu_req_o     = apu_req;
    bus.apu_payload_o = payload[winner];
    bus.apu_ready_o   = apu_ready;
    bus.m_result_o    = bus.apu_result_i;

    bus.m_gnt_o         = '0;
    bus.m_gnt_o[winner] = accept;

    bus.m_valid_o = '0;
    if (owner_vld) bus.m_valid_o[owner] = bus.apu_valid_i;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q | (bus.apu_valid_i & fifo_empty & ~accept);

    if (accept) begin
      rr_ptr_d = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
    end

    unique case (state_q)
      ARB_OPEN: begin
        if (apu_req && !bus.apu_gnt_i) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = winner;
        end
      end
      ARB_LOCKED: begin
        if (accept) state_d = ARB_OPEN;
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  apu_arb_tag_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (winner),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy_o = (fifo_count != '0);
  assign err_o  = err_q;

endmodule
